csr_bus_arbiter: RTL and testbench

//   Shares the single-port 8-entry CSR register block (en/we/addr/wdata/rdata bus) between NREQ

---
 rtl/csr_arb_pkg.sv | 31 +++
 rtl/csr_rr_pick.sv | 26 ++
 rtl/csr_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_csr_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_arb_pkg.sv
// Shared types and helpers for the CSR bus arbiter: FSM state encoding, default
// bus widths and the round-robin search function used by the picker.
package csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } csr_arb_state_e;

  localparam int CSR_ADDR_W = 5;
  localparam int CSR_DATA_W = 8;
  localparam int MAX_REQ    = 8;

  // Returns {valid, index}: first set bit of req searching upward from last+1
  // with wrap over nreq requesters. Scanning downward lets the nearest hit win.
  function automatic logic [3:0] rr_next(input logic [2:0]         last,
                                         input logic [MAX_REQ-1:0] req,
                                         input int                 nreq);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k <= nreq && req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_rr_pick.sv
// Combinational round-robin picker: given the request vector and the last
// granted index, reports whether anyone is requesting and who wins.
module csr_rr_pick
  import csr_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_last,
  output logic            o_valid,
  output logic [2:0]      o_gidx
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [3:0]         w_pick;

  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NREQ-1:0]   = i_req;
    w_pick                = rr_next(i_last, w_req_ext, NREQ);
  end

  assign o_valid = w_pick[3];
  assign o_gidx  = w_pick[2:0];

endmodule

// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing one CSR register bus among NREQ requesters.
// Optional write-permission checking is enabled with `define CSR_ARB_ERR_EN.
module csr_bus_arbiter
  import csr_arb_pkg::*;
#(
  parameter int              NREQ    = 2,
  parameter int              ADDR_W  = CSR_ADDR_W,
  parameter int              DATA_W  = CSR_DATA_W,
  parameter logic [NREQ-1:0] WR_PERM = '1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_req_we,
  input  logic [NREQ*ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*DATA_W-1:0] i_req_wdata,
  output logic [NREQ-1:0]        o_ack,
  output logic [DATA_W-1:0]      o_ack_rdata,
`ifdef CSR_ARB_ERR_EN
  output logic                   o_ack_err,
`endif
  output logic                   o_bus_en,
  output logic                   o_bus_we,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic [DATA_W-1:0]      o_bus_wdata,
  input  logic [DATA_W-1:0]      i_bus_rdata,
  output csr_arb_state_e         o_state
);

  // Handshake: a requester raises req[i] with its command and holds both until
  // it sees the one-cycle ack[i]; it may present a new command the next cycle.

`ifdef CSR_ARB_ERR_EN
  localparam logic [MAX_REQ-1:0] PERM_EXT = MAX_REQ'(WR_PERM);
`else
  localparam logic [MAX_REQ-1:0] PERM_EXT = MAX_REQ'(WR_PERM) | {MAX_REQ{1'b1}};
`endif

  csr_arb_state_e    r_state;
  logic              r_bus_en;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [2:0]        r_gidx;
  logic [2:0]        r_last;
`ifdef CSR_ARB_ERR_EN
  logic              r_err;
`endif

  logic              w_valid;
  logic [2:0]        w_gidx;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_reject;

  csr_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_gidx  (w_gidx)
  );

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == 3'(i)) begin
        w_we    = i_req_we[i];
        w_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        w_wdata = i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A rejected write still takes the ISSUE/RESP slots but never strobes the bus.
  assign w_reject = w_we && !PERM_EXT[w_gidx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bus_en    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_gidx      <= '0;
      r_last      <= 3'(NREQ-1);
`ifdef CSR_ARB_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_bus_en    <= !w_reject;
            r_bus_we    <= w_we;
            r_bus_addr  <= w_addr;
            r_bus_wdata <= w_wdata;
            r_gidx      <= w_gidx;
            r_last      <= w_gidx;
`ifdef CSR_ARB_ERR_EN
            r_err       <= w_reject;
`endif
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_bus_en <= 1'b0;
          r_state  <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gidx == 3'(i)) o_ack[i] = (r_state == RESP);
    end
  end

  assign o_ack_rdata = i_bus_rdata;
`ifdef CSR_ARB_ERR_EN
  assign o_ack_err   = (r_state == RESP) && r_err;
`endif
  assign o_bus_en    = r_bus_en;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_state     = r_state;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Bench for csr_bus_arbiter: CSR target stub, transaction-level reference model,
// directed scenarios and randomized multi-requester traffic.
module tb_csr_bus_arbiter;
  import csr_arb_pkg::*;

  localparam int              NREQ = 3;
  localparam int              AW   = 5;
  localparam int              DW   = 8;
  localparam logic [NREQ-1:0] PERM = 3'b101;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        ack_rdata;
  logic                 ack_err;
  logic                 bus_en;
  logic                 bus_we;
  logic [AW-1:0]        bus_addr;
  logic [DW-1:0]        bus_wdata;
  logic [DW-1:0]        bus_rdata;
  csr_arb_state_e       state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  csr_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .WR_PERM(PERM)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_ack       (ack),
    .o_ack_rdata (ack_rdata),
`ifdef CSR_ARB_ERR_EN
    .o_ack_err   (ack_err),
`endif
    .o_bus_en    (bus_en),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_rdata (bus_rdata),
    .o_state     (state)
  );
`ifndef CSR_ARB_ERR_EN
  assign ack_err = 1'b0;
`endif

  // CSR target stub: 8 entries decoded by addr[4:2], registered read data.
  logic [DW-1:0] csr_mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus_en) begin
      if (bus_we) csr_mem[bus_addr[4:2]] <= bus_wdata;
      else        bus_rdata <= csr_mem[bus_addr[4:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] shadow [8] = '{default: 8'h00};
  logic [DW-1:0] exp_q[$];
  bit            m_started = 0;
  int            m_phase   = 0;   // 0 waiting, 1 access cycle, 2 response cycle
  int            m_gidx    = 0;
  int            m_last    = NREQ-1;
  bit            m_we      = 0;
  bit            m_err     = 0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_wdata   = '0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_phase == 1 && !m_err && m_we) shadow[m_addr[4:2]] = m_wdata;
      m_phase = 0; m_last = NREQ-1; m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_gidx = 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (|req) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req[(m_last + k) % NREQ]) begin
            m_gidx = (m_last + k) % NREQ;
            break;
          end
        end
        m_last  = m_gidx;
        m_we    = req_we[m_gidx];
        m_addr  = req_addr[m_gidx*AW +: AW];
        m_wdata = req_wdata[m_gidx*DW +: DW];
`ifdef CSR_ARB_ERR_EN
        m_err   = m_we && !PERM[m_gidx];
`else
        m_err   = 0;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!m_err) begin
        if (m_we) shadow[m_addr[4:2]] = m_wdata;
        else      exp_q.push_back(shadow[m_addr[4:2]]);
      end
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ack;
    logic [DW-1:0]   e_rd;
    if (m_started) begin
      e_ack = '0;
      if (m_phase == 2) e_ack[m_gidx] = 1'b1;
      chk("bus_en", bus_en, (m_phase == 1) && !m_err);
      chk("bus_we", bus_we, m_we);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("ack", ack, e_ack);
      chk("state", state, (m_phase == 0) ? IDLE : (m_phase == 1) ? ISSUE : RESP);
`ifdef CSR_ARB_ERR_EN
      chk("ack_err", ack_err, (m_phase == 2) && m_err);
`endif
      if (m_phase == 2 && !m_we && !m_err) begin
        if (exp_q.size() == 0) chk("rdata_queue", 0, 1);
        else begin
          e_rd = exp_q.pop_front();
          chk("ack_rdata", ack_rdata, e_rd);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req[i]                = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_state", state, IDLE);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int i, output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (ack[i]) done = 1;
      else if (n > 40) begin
        chk("ack_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic wait_idle_drained();
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int order [4];
    int when  [4];
    int cnt;
    bit saw_en;
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    do_reset();

    // Single write: one-cycle strobe then ack two cycles after the request.
    set_cmd(0, 1'b1, 5'h08, 8'hA5);
    @(negedge clk);
    chk("t1_bus_en", bus_en, 1);
    chk("t1_addr", bus_addr, 5'h08);
    chk("t1_wdata", bus_wdata, 8'hA5);
    chk("t1_we", bus_we, 1);
    @(negedge clk);
    chk("t1_ack", ack, 3'b001);
    chk("t1_en_off", bus_en, 0);
    chk("t1_csr2", csr_mem[2], 8'hA5);
    req[0] = 1'b0;

    // Preload CSR[3] then read it back through requester 1.
    set_cmd(0, 1'b1, 5'h0C, 8'h3C);
    wait_ack(0, n);
    req[0] = 1'b0;
    set_cmd(1, 1'b0, 5'h0C, 8'h00);
    wait_ack(1, n);
    chk("t2_rdata", ack_rdata, 8'h3C);
    req[1] = 1'b0;

    // Reset during ISSUE of a write: bus drops, no ack, write itself sticks.
    set_cmd(0, 1'b1, 5'h14, 8'h77);
    cnt = 0;
    while (state != ISSUE && cnt < 10) begin @(negedge clk); cnt++; end
    chk("t5_reached_issue", state, ISSUE);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t5_en", bus_en, 0);
    chk("t5_state", state, IDLE);
    chk("t5_ack", ack, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ack_after", ack, 0);
    set_cmd(1, 1'b0, 5'h14, 8'h00);
    wait_ack(1, n);
    chk("t5_rdata", ack_rdata, 8'h77);
    req[1] = 1'b0;

    // Contention from reset: alternating grants, 3-cycle spacing.
    @(negedge clk);
    rst = 1'b1;
    set_cmd(0, 1'b0, 5'h08, 8'h00);
    set_cmd(1, 1'b0, 5'h0C, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 4; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        order[cnt] = ack[1] ? 1 : 0;
        when[cnt]  = c;
        cnt++;
      end
    end
    chk("t3_count", cnt, 4);
    chk("t3_g0", order[0], 0);
    chk("t3_g1", order[1], 1);
    chk("t3_g2", order[2], 0);
    chk("t3_g3", order[3], 1);
    chk("t3_space1", when[1] - when[0], 3);
    chk("t3_space3", when[3] - when[2], 3);
    chk("t3_first", when[0], 1);
    wait_idle_drained();

    // Fairness: requester 1 hammers, requester 0 still served quickly.
    set_cmd(1, 1'b0, 5'h08, 8'h00);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    set_cmd(0, 1'b0, 5'h0C, 8'h00);
    wait_ack(0, n);
    chk("t4_wait_le6", n <= 6, 1);
    wait_idle_drained();

`ifdef CSR_ARB_ERR_EN
    // Write from a requester without permission is rejected without a bus access.
    set_cmd(1, 1'b1, 5'h00, 8'hFF);
    saw_en = 0;
    cnt = 0;
    while (!ack[1] && cnt < 20) begin
      @(negedge clk);
      saw_en |= bus_en;
      cnt++;
    end
    chk("t6_ack", ack, 3'b010);
    chk("t6_err", ack_err, 1);
    chk("t6_no_bus", saw_en, 0);
    req[1] = 1'b0;
    @(negedge clk);
    chk("t6_csr0", csr_mem[0], 8'h00);
    set_cmd(1, 1'b0, 5'h00, 8'h00);
    wait_ack(1, n);
    chk("t6_read_ok", ack_err, 0);
    wait_idle_drained();
`else
    saw_en = 0;
`endif

    // Random traffic with occasional reset.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          else set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)));
        end
      end
    end
    rst = 1'b0;
    wait_idle_drained();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
